// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers returned words in a 2-entry FIFO that feeds decode over valid/ready.
module fetch_unit #(
  parameter int                INSTR_W  = 19,
  parameter int                ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_addr;
  logic               inflight;
  logic               drop;
  logic [1:0]         count;

  // Shift-style FIFO: entry 0 is always the head, so outputs come straight from flops.
  logic [INSTR_W-1:0] q_instr0, q_instr1;
  logic [ADDR_W-1:0]  q_pc0, q_pc1;

  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         occupancy;

  assign instr_valid = (count != 2'd0);
  assign instr_out   = q_instr0;
  assign pc_out      = q_pc0;
  assign imem_addr   = pc;
  assign imem_req    = issue;

  // Occupancy counts buffered words plus the one in flight, net of this cycle's pop.
  always_comb begin
    pop       = instr_valid & instr_ready;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = !rst && !redirect_valid && (occupancy < 3'd2);
    push      = inflight && !drop && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      inflight_addr <= RESET_PC;
      inflight      <= 1'b0;
      drop          <= 1'b0;
      count         <= 2'd0;
      q_instr0      <= '0;
      q_instr1      <= '0;
      q_pc0         <= '0;
      q_pc1         <= '0;
    end else begin
      inflight <= issue;
      drop     <= redirect_valid & inflight;
      if (issue) begin
        inflight_addr <= pc;
        pc            <= pc + 1'b1;
      end
      if (redirect_valid) begin
        pc    <= redirect_pc;
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              q_instr0 <= imem_rdata;
              q_pc0    <= inflight_addr;
            end else begin
              q_instr1 <= imem_rdata;
              q_pc1    <= inflight_addr;
            end
            count <= count + 1'b1;
          end
          2'b01: begin
            q_instr0 <= q_instr1;
            q_pc0    <= q_pc1;
            count    <= count - 1'b1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              q_instr0 <= imem_rdata;
              q_pc0    <= inflight_addr;
            end else begin
              q_instr0 <= q_instr1;
              q_pc0    <= q_pc1;
              q_instr1 <= imem_rdata;
              q_pc1    <= inflight_addr;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
